rsp_s2_prep_pg_ram_ctrl: RTL and testbench

Owns the single-port twiddle RAM (TWIDDLE_NUM x DATA_WIDTH) in the phase-generation stage of rsp_s2_prep.
Sequences table load, then shares the RAM between the phase-generation read path and configuration readback.
The phase-generation read path has absolute priority during a symbol.
Tracks table validity and symbol progress, aligns read-data valid with RAM latency, and flags protocol errors.

---
 rtl/rsp_s2_prep_pg_ram_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_rsp_s2_prep_pg_ram_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rsp_s2_prep_pg_ram_ctrl.sv
// Twiddle RAM controller for the rsp_s2_prep phase-generation stage: loads the table,
// then shares the single-port RAM between phase-gen reads (priority) and config readback.
module rsp_s2_prep_pg_ram_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 64,
    parameter int TWIDDLE_NUM = 136,
    parameter int RAM_DELAY   = 2,
    parameter int DATA_NUM    = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_cfg_load_start,
    input  logic                        i_cfg_wr_valid,
    input  logic [DATA_WIDTH-1:0]       i_cfg_wr_data,
    output logic                        o_cfg_wr_ready,
    input  logic                        i_cfg_rd_req,
    input  logic [ADDR_WIDTH-1:0]       i_cfg_rd_addr,
    output logic                        o_cfg_rd_ack,
    output logic                        o_cfg_rd_valid,
    output logic [DATA_WIDTH-1:0]       o_cfg_rd_data,
    input  logic                        i_sym_start,
    input  logic                        i_pg_rd_valid,
    input  logic [ADDR_WIDTH-1:0]       i_pg_rd_addr,
    input  logic                        i_pg_rd_last,
    output logic                        o_pg_rd_valid,
    output logic [DATA_WIDTH-1:0]       o_pg_rd_data,
    output logic                        o_ram_en,
    output logic                        o_ram_wen,
    output logic [ADDR_WIDTH-1:0]       o_ram_addr,
    output logic [DATA_WIDTH-1:0]       o_ram_din,
    input  logic [DATA_WIDTH-1:0]       i_ram_dout,
    output logic                        o_table_ready,
    output logic                        o_busy,
    output logic [$clog2(DATA_NUM):0]   o_sym_cnt,
    input  logic                        i_err_clr,
    output logic [3:0]                  o_err
);

    localparam int CNT_W = $clog2(DATA_NUM) + 1;
    localparam int DRN_W = $clog2(RAM_DELAY + 1) + 1;
    localparam logic [ADDR_WIDTH:0]   TW_NUM   = (ADDR_WIDTH + 1)'(TWIDDLE_NUM);
    localparam logic [ADDR_WIDTH-1:0] TW_LAST  = ADDR_WIDTH'(TWIDDLE_NUM - 1);
    localparam logic [CNT_W-1:0]      SYM_MAX  = CNT_W'(DATA_NUM);
    localparam logic [DRN_W-1:0]      DRN_LAST = DRN_W'(RAM_DELAY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   load_cnt_q;
    logic [CNT_W-1:0]        sym_cnt_q;
    logic [CNT_W-1:0]        sym_cnt_d;
    logic [DRN_W-1:0]        drn_cnt_q;
    logic [3:0]              err_q;
    logic [3:0]              err_set;
    logic                    cfg_ack_q;
    logic                    table_ready_q;
    logic [RAM_DELAY:0]      pg_vld_p;
    logic [RAM_DELAY:0]      cfg_vld_p;

    logic                    in_load;
    logic                    load_restart;
    logic                    wr_acc;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    sym_go;
    logic                    pg_acc;
    logic                    sym_end;
    logic                    cfg_grant;

    function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} >= TW_NUM);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] clamp_addr(input logic [ADDR_WIDTH-1:0] a);
        return addr_oor(a) ? TW_LAST : a;
    endfunction

    always_comb begin
        state_d      = state_q;
        in_load      = (state_q == S_LOAD);
        load_restart = in_load & i_cfg_load_start;
        wr_acc       = in_load & i_cfg_wr_valid;
        wr_addr      = load_restart ? '0 : load_cnt_q;
        // A symbol start in READY makes that very cycle behave as RUN.
        sym_go       = (state_q == S_READY) & i_sym_start;
        pg_acc       = i_pg_rd_valid & ((state_q == S_RUN) | sym_go);
        cfg_grant    = i_cfg_rd_req & (state_q == S_READY) & ~i_sym_start & ~cfg_ack_q;

        sym_cnt_d = sym_go ? '0 : sym_cnt_q;
        if (pg_acc && (sym_cnt_d != SYM_MAX)) begin
            sym_cnt_d = sym_cnt_d + CNT_W'(1);
        end
        sym_end = pg_acc & (i_pg_rd_last | (sym_cnt_d == SYM_MAX));

        err_set = {i_cfg_load_start & ((state_q == S_RUN) | (state_q == S_DRAIN)),
                   pg_acc & addr_oor(i_pg_rd_addr),
                   i_pg_rd_valid & ~pg_acc,
                   i_cfg_wr_valid & ~in_load};

        case (state_q)
            S_IDLE: begin
                if (i_cfg_load_start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (wr_acc && (wr_addr == TW_LAST)) state_d = S_READY;
            end
            S_READY: begin
                if (sym_go)                state_d = sym_end ? S_DRAIN : S_RUN;
                else if (i_cfg_load_start) state_d = S_LOAD;
            end
            S_RUN: begin
                if (sym_end) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drn_cnt_q == DRN_LAST) state_d = S_READY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            load_cnt_q    <= '0;
            sym_cnt_q     <= '0;
            drn_cnt_q     <= '0;
            err_q         <= '0;
            cfg_ack_q     <= 1'b0;
            table_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sym_cnt_q     <= sym_cnt_d;
            cfg_ack_q     <= cfg_grant;
            table_ready_q <= (state_q == S_READY) | (state_q == S_RUN) | (state_q == S_DRAIN);
            drn_cnt_q     <= (state_q == S_DRAIN) ? drn_cnt_q + DRN_W'(1) : '0;
            // The error set wins over a simultaneous clear.
            err_q         <= (i_err_clr ? 4'b0000 : err_q) | err_set;
            if (wr_acc) begin
                load_cnt_q <= wr_addr + ADDR_WIDTH'(1);
            end else if (i_cfg_load_start && (state_q != S_RUN) && (state_q != S_DRAIN)) begin
                load_cnt_q <= '0;
            end
        end
    end

    // Stage p0: registered RAM command, one cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_ram_en   <= 1'b0;
            o_ram_wen  <= 1'b0;
            o_ram_addr <= '0;
            o_ram_din  <= '0;
        end else if (wr_acc) begin
            o_ram_en   <= 1'b1;
            o_ram_wen  <= 1'b1;
            o_ram_addr <= wr_addr;
            o_ram_din  <= i_cfg_wr_data;
        end else if (pg_acc) begin
            o_ram_en   <= 1'b1;
            o_ram_wen  <= 1'b0;
            o_ram_addr <= clamp_addr(i_pg_rd_addr);
        end else if (cfg_grant) begin
            o_ram_en   <= 1'b1;
            o_ram_wen  <= 1'b0;
            o_ram_addr <= clamp_addr(i_cfg_rd_addr);
        end else begin
            o_ram_en   <= 1'b0;
            o_ram_wen  <= 1'b0;
        end
    end

    // Stages p0..pN: read tags ride alongside the RAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pg_vld_p  <= '0;
            cfg_vld_p <= '0;
        end else begin
            pg_vld_p[0]  <= pg_acc;
            cfg_vld_p[0] <= cfg_grant;
            for (int i = 1; i <= RAM_DELAY; i++) begin
                pg_vld_p[i]  <= pg_vld_p[i-1];
                cfg_vld_p[i] <= cfg_vld_p[i-1];
            end
        end
    end

    assign o_cfg_wr_ready = (state_q == S_LOAD);
    assign o_cfg_rd_ack   = cfg_ack_q;
    assign o_cfg_rd_valid = cfg_vld_p[RAM_DELAY];
    assign o_cfg_rd_data  = cfg_vld_p[RAM_DELAY] ? i_ram_dout : '0;
    assign o_pg_rd_valid  = pg_vld_p[RAM_DELAY];
    assign o_pg_rd_data   = pg_vld_p[RAM_DELAY] ? i_ram_dout : '0;
    assign o_table_ready  = table_ready_q;
    assign o_busy         = (state_q == S_LOAD) | (state_q == S_RUN) | (state_q == S_DRAIN);
    assign o_sym_cnt      = sym_cnt_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_rsp_s2_prep_pg_ram_ctrl.sv
// Directed bench for rsp_s2_prep_pg_ram_ctrl with a 2-cycle-latency RAM model.
module tb_rsp_s2_prep_pg_ram_ctrl;

    localparam int AW  = 8;
    localparam int DW  = 64;
    localparam int TWN = 136;
    localparam int RD  = 2;
    localparam int DN  = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_cfg_load_start, i_cfg_wr_valid, i_cfg_rd_req;
    logic [DW-1:0] i_cfg_wr_data;
    logic [AW-1:0] i_cfg_rd_addr, i_pg_rd_addr;
    logic          i_sym_start, i_pg_rd_valid, i_pg_rd_last, i_err_clr;
    logic          o_cfg_wr_ready, o_cfg_rd_ack, o_cfg_rd_valid, o_pg_rd_valid;
    logic [DW-1:0] o_cfg_rd_data, o_pg_rd_data, o_ram_din, ram_dout;
    logic          o_ram_en, o_ram_wen, o_table_ready, o_busy;
    logic [AW-1:0] o_ram_addr;
    logic [10:0]   o_sym_cnt;
    logic [3:0]    o_err;

    always #5 clk = ~clk;

    rsp_s2_prep_pg_ram_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .i_cfg_load_start(i_cfg_load_start), .i_cfg_wr_valid(i_cfg_wr_valid),
        .i_cfg_wr_data(i_cfg_wr_data), .o_cfg_wr_ready(o_cfg_wr_ready),
        .i_cfg_rd_req(i_cfg_rd_req), .i_cfg_rd_addr(i_cfg_rd_addr),
        .o_cfg_rd_ack(o_cfg_rd_ack), .o_cfg_rd_valid(o_cfg_rd_valid),
        .o_cfg_rd_data(o_cfg_rd_data), .i_sym_start(i_sym_start),
        .i_pg_rd_valid(i_pg_rd_valid), .i_pg_rd_addr(i_pg_rd_addr),
        .i_pg_rd_last(i_pg_rd_last), .o_pg_rd_valid(o_pg_rd_valid),
        .o_pg_rd_data(o_pg_rd_data), .o_ram_en(o_ram_en), .o_ram_wen(o_ram_wen),
        .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din), .i_ram_dout(ram_dout),
        .o_table_ready(o_table_ready), .o_busy(o_busy), .o_sym_cnt(o_sym_cnt),
        .i_err_clr(i_err_clr), .o_err(o_err)
    );

    // Single-port RAM, dout two cycles after en.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] rd_p0;
    always @(posedge clk) begin
        if (o_ram_en) begin
            if (o_ram_wen) mem[o_ram_addr] <= o_ram_din;
            else           rd_p0 <= mem[o_ram_addr];
        end
        ram_dout <= rd_p0;
    end

    typedef struct { int due; logic [DW-1:0] data; } exp_t;
    exp_t pg_q[$];
    exp_t cfg_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_wr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pg(input logic [DW-1:0] d);
        exp_t e;
        e.due  = cyc + RD + 1;
        e.data = d;
        pg_q.push_back(e);
    endtask

    task automatic push_cfg(input logic [DW-1:0] d);
        exp_t e;
        e.due  = cyc + RD + 1;
        e.data = d;
        cfg_q.push_back(e);
    endtask

    // Read-valid timing/data and table-write order, sampled mid-cycle.
    always @(negedge clk) begin
        if (pg_q.size() > 0 && pg_q[0].due == cyc) begin
            check("pg_rd_valid", o_pg_rd_valid, 1);
            check("pg_rd_data", o_pg_rd_data, pg_q[0].data);
            void'(pg_q.pop_front());
        end else begin
            check("pg_rd_idle", o_pg_rd_valid, 0);
        end
        if (cfg_q.size() > 0 && cfg_q[0].due == cyc) begin
            check("cfg_rd_valid", o_cfg_rd_valid, 1);
            check("cfg_rd_data", o_cfg_rd_data, cfg_q[0].data);
            void'(cfg_q.pop_front());
        end else begin
            check("cfg_rd_idle", o_cfg_rd_valid, 0);
        end
        if (o_ram_en && o_ram_wen) begin
            check("wr_addr", o_ram_addr, 64'(n_wr));
            check("wr_din", o_ram_din, 64'(n_wr));
            n_wr++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        i_cfg_load_start = 0; i_cfg_wr_valid = 0; i_cfg_wr_data = '0;
        i_cfg_rd_req = 0; i_cfg_rd_addr = '0; i_sym_start = 0;
        i_pg_rd_valid = 0; i_pg_rd_addr = '0; i_pg_rd_last = 0; i_err_clr = 0;
        tick(); tick(); tick();
        check("rst_ram_en", o_ram_en, 0);
        check("rst_ram_wen", o_ram_wen, 0);
        check("rst_ram_addr", o_ram_addr, 0);
        check("rst_ram_din", o_ram_din, 0);
        check("rst_table_ready", o_table_ready, 0);
        check("rst_busy", o_busy, 0);
        check("rst_sym_cnt", o_sym_cnt, 0);
        check("rst_err", o_err, 0);
        check("rst_wr_ready", o_cfg_wr_ready, 0);
        check("rst_rd_ack", o_cfg_rd_ack, 0);
        rst_n = 1'b1;
        tick();

        // Table load, valid every other cycle.
        i_cfg_load_start = 1; tick(); i_cfg_load_start = 0;
        check("load_wr_ready", o_cfg_wr_ready, 1);
        check("load_busy", o_busy, 1);
        for (int n = 0; n < TWN; n++) begin
            i_cfg_wr_valid = 1; i_cfg_wr_data = 64'(n);
            tick();
            i_cfg_wr_valid = 0;
            if (n == TWN - 1) begin
                check("last_wr_tr_low", o_table_ready, 0);
                check("last_wr_wen", o_ram_wen, 1);
                check("last_wr_addr", o_ram_addr, 135);
            end
            tick();
        end
        check("loaded_table_ready", o_table_ready, 1);
        check("loaded_busy", o_busy, 0);
        check("loaded_wr_ready", o_cfg_wr_ready, 0);
        check("write_count", n_wr, TWN);

        // Extra word after the table is full.
        i_cfg_wr_valid = 1; i_cfg_wr_data = 64'd999; tick(); i_cfg_wr_valid = 0;
        check("overflow_err", o_err, 4'b0001);
        check("overflow_no_wr", o_ram_en, 0);
        i_err_clr = 1; tick(); i_err_clr = 0;
        check("err_clear0", o_err, 0);

        // Readback addr 5, then clamped addr 200.
        i_cfg_rd_req = 1; i_cfg_rd_addr = 8'd5; push_cfg(64'd5); tick();
        check("rb5_ack", o_cfg_rd_ack, 1);
        check("rb5_ram_en", o_ram_en, 1);
        check("rb5_ram_wen", o_ram_wen, 0);
        check("rb5_ram_addr", o_ram_addr, 5);
        i_cfg_rd_req = 0; tick();
        check("rb5_ack_pulse", o_cfg_rd_ack, 0);
        tick(); tick();
        i_cfg_rd_req = 1; i_cfg_rd_addr = 8'd200; push_cfg(64'd135); tick();
        check("rb200_ack", o_cfg_rd_ack, 1);
        check("rb200_ram_addr", o_ram_addr, 135);
        i_cfg_rd_req = 0; tick(); tick(); tick();
        check("rb200_no_err", o_err, 0);

        // Full symbol of back-to-back reads; readback raised mid-symbol.
        for (int i = 0; i < DN; i++) begin
            i_sym_start = (i == 0); i_pg_rd_valid = 1; i_pg_rd_addr = AW'(i % TWN);
            if (i == 500) begin
                i_cfg_rd_req = 1; i_cfg_rd_addr = 8'd7;
            end
            push_pg(64'(i % TWN));
            tick();
            if (i == 0)   check("sym_cnt_first", o_sym_cnt, 1);
            if (i == 600) check("run_no_ack", o_cfg_rd_ack, 0);
        end
        i_sym_start = 0; i_pg_rd_valid = 0;
        check("sym_cnt_full", o_sym_cnt, 1024);
        check("drain_table_ready", o_table_ready, 1);
        for (int j = 1; j <= 4; j++) begin
            check("drain_stall_ack", o_cfg_rd_ack, 0);
            check("drain_busy", o_busy, (j <= 3) ? 1 : 0);
            if (j == 4) push_cfg(64'd7);
            tick();
        end
        check("post_drain_ack", o_cfg_rd_ack, 1);
        i_cfg_rd_req = 0;
        tick(); tick(); tick(); tick();

        // Out-of-range pg address with last, then pg read outside RUN.
        i_sym_start = 1; i_pg_rd_valid = 1; i_pg_rd_addr = 8'd200; i_pg_rd_last = 1;
        push_pg(64'd135); tick();
        i_sym_start = 0; i_pg_rd_valid = 0; i_pg_rd_last = 0;
        check("oor_ram_en", o_ram_en, 1);
        check("oor_ram_wen", o_ram_wen, 0);
        check("oor_ram_addr", o_ram_addr, 135);
        check("oor_err", o_err, 4'b0100);
        check("oor_sym_cnt", o_sym_cnt, 1);
        tick(); tick(); tick();
        check("oor_back_ready", o_busy, 0);
        i_pg_rd_valid = 1; i_pg_rd_addr = 8'd3; tick(); i_pg_rd_valid = 0;
        check("idle_pg_no_ram", o_ram_en, 0);
        check("idle_pg_err", o_err, 4'b0110);
        i_err_clr = 1; i_pg_rd_valid = 1; tick(); i_pg_rd_valid = 0;
        check("err_set_wins", o_err, 4'b0010);
        tick(); i_err_clr = 0;
        check("err_clear1", o_err, 0);

        // Load request during RUN, then reset with reads in flight.
        i_sym_start = 1; i_pg_rd_valid = 1; i_pg_rd_addr = 8'd1; push_pg(64'd1); tick();
        i_sym_start = 0; i_pg_rd_addr = 8'd2; i_cfg_load_start = 1; push_pg(64'd2); tick();
        i_cfg_load_start = 0;
        check("run_load_err", o_err, 4'b1000);
        check("run_busy", o_busy, 1);
        check("run_sym_cnt", o_sym_cnt, 2);
        i_pg_rd_addr = 8'd3; push_pg(64'd3); tick();
        i_pg_rd_valid = 0;
        pg_q.delete();
        rst_n = 1'b0;
        #1;
        check("mid_rst_pg_valid", o_pg_rd_valid, 0);
        check("mid_rst_pg_data", o_pg_rd_data, 0);
        check("mid_rst_ram_en", o_ram_en, 0);
        check("mid_rst_ram_addr", o_ram_addr, 0);
        check("mid_rst_table_ready", o_table_ready, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_sym_cnt", o_sym_cnt, 0);
        check("mid_rst_err", o_err, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        check("post_rst_busy", o_busy, 0);
        check("post_rst_table_ready", o_table_ready, 0);
        i_cfg_rd_req = 1; i_cfg_rd_addr = 8'd5; tick();
        check("idle_no_ack", o_cfg_rd_ack, 0);
        i_cfg_rd_req = 0;
        tick(); tick(); tick();
        check("pg_q_drained", pg_q.size(), 0);
        check("cfg_q_drained", cfg_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
